// File: rtl/mem_if_pkg.sv
// Shared definitions for the processor memory interface.
//   - access_size encodings (burst length selector)
//   - rw encodings
//   - responder FSM state type
//   - burst_len(): access_size -> number of beats
//   - default byte address of RAM word 0
package mem_if_pkg;

    localparam logic [1:0] SZ_1  = 2'b00;
    localparam logic [1:0] SZ_4  = 2'b01;
    localparam logic [1:0] SZ_8  = 2'b10;
    localparam logic [1:0] SZ_16 = 2'b11;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [31:0] START_ADDR = 32'h8002_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST_WR = 2'd1,
        BURST_RD = 2'd2
    } state_e;

    // Number of beats in a burst; 5 bits so that 16 is representable.
    function automatic logic [4:0] burst_len(input logic [1:0] sz);
        logic [4:0] n;
        case (sz)
            SZ_1:    n = 5'd1;
            SZ_4:    n = 5'd4;
            SZ_8:    n = 5'd8;
            default: n = 5'd16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Single-port synchronous word RAM with registered read.
//   clk_i    : rising-edge clock
//   we_i     : write enable; wdata_i stored at idx_i on the edge
//   re_i     : read enable; rdata_o loads the word at idx_i on the edge
//   idx_i    : word index
//   wdata_i  : write data
//   rdata_o  : registered read data, holds between reads
// Contents are never cleared.
module mem_word_ram #(
    parameter int unsigned data_width  = 32,
    parameter int unsigned depth_words = 262144,
    parameter int unsigned idx_width   = $clog2(depth_words)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [idx_width-1:0]  idx_i,
    input  logic [data_width-1:0] wdata_i,
    output logic [data_width-1:0] rdata_o
);

    logic [data_width-1:0] mem_q [depth_words];
    logic [data_width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the processor memory interface. Accepts single
// and burst (4/8/16 word) read/write requests and backs them with a word RAM
// mapped at start_addr.
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   address     : byte address, sampled only when a request is accepted
//   data_in     : write data, sampled on every write beat edge
//   access_size : burst length 00=1, 01=4, 10=8, 11=16
//   rw          : 0=write, 1=read
//   enable      : request valid; must stay high for the whole burst
//   busy        : high while a burst has beats remaining after this edge
//   data_out    : read data, valid while data_valid is high, else holds
//   data_valid  : one-cycle strobe per read beat
//   range_err   : one-cycle strobe per beat outside the mapped window
module burst_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned              data_width    = 32,
    parameter int unsigned              address_width = 32,
    parameter int unsigned              depth_words   = 262144,
    parameter logic [address_width-1:0] start_addr    = address_width'(START_ADDR)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [address_width-1:0] address,
    input  logic [data_width-1:0]    data_in,
    input  logic [1:0]               access_size,
    input  logic                     rw,
    input  logic                     enable,
    output logic                     busy,
    output logic [data_width-1:0]    data_out,
    output logic                     data_valid,
    output logic                     range_err
);

    localparam int unsigned IDX_W = $clog2(depth_words);

    // Window bounds one bit wider than the address so the top bound cannot wrap.
    localparam logic [address_width:0] WIN_LO = {1'b0, start_addr};
    localparam logic [address_width:0] WIN_HI =
        WIN_LO + (address_width+1)'(64'(depth_words) << 2);

    state_e                   state_q, state_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [3:0]               left_q, left_d;
    logic                     busy_q, busy_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic                     zero_q, zero_d;

    logic                     beat;
    logic                     beat_rd;
    logic [address_width-1:0] beat_addr;
    logic                     in_range;
    logic [IDX_W-1:0]         ram_idx;
    logic                     ram_we;
    logic                     ram_re;
    logic [data_width-1:0]    ram_rdata;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        left_d    = left_q;
        beat      = 1'b0;
        beat_rd   = 1'b0;
        beat_addr = addr_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    beat      = 1'b1;
                    beat_rd   = (rw == RW_READ);
                    beat_addr = address & ~address_width'(3);
                    if (burst_len(access_size) != 5'd1) begin
                        state_d = (rw == RW_READ) ? BURST_RD : BURST_WR;
                        left_d  = 4'(burst_len(access_size) - 5'd1);
                        addr_d  = beat_addr + address_width'(4);
                    end
                end
            end
            BURST_WR, BURST_RD: begin
                if (!enable) begin
                    // Abort: this edge executes no beat.
                    state_d = IDLE;
                    left_d  = '0;
                end else begin
                    beat    = 1'b1;
                    beat_rd = (state_q == BURST_RD);
                    left_d  = left_q - 4'd1;
                    addr_d  = addr_q + address_width'(4);
                    if (left_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                left_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign in_range = ({1'b0, beat_addr} >= WIN_LO) && ({1'b0, beat_addr} < WIN_HI);
    assign ram_idx  = IDX_W'((beat_addr - start_addr) >> 2);
    assign ram_we   = beat && !beat_rd && in_range;
    assign ram_re   = beat && beat_rd && in_range;

    always_comb begin
        valid_d = beat && beat_rd;
        err_d   = beat && !in_range;
        // zero_q only changes on read beats so data_out holds otherwise.
        zero_d  = (beat && beat_rd) ? !in_range : zero_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    mem_word_ram #(
        .data_width (data_width),
        .depth_words(depth_words),
        .idx_width  (IDX_W)
    ) u_ram (
        .clk_i  (clock),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .idx_i  (ram_idx),
        .wdata_i(data_in),
        .rdata_o(ram_rdata)
    );

    // The RAM's read register is not reset; zero_q forces data_out to 0
    // after reset and for out-of-range reads.
    assign data_out   = zero_q ? '0 : ram_rdata;
    assign busy       = busy_q;
    assign data_valid = valid_q;
    assign range_err  = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

    localparam logic [31:0] BASE    = 32'h8002_0000;
    localparam logic [63:0] WIN_END = 64'h8002_0000 + 64'd1048576;
    localparam logic [31:0] END_A   = 32'h8012_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  access_size = '0;
    logic        rw = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic        range_err;

    always #5 clock = ~clock;

    burst_mem_responder #(
        .data_width   (32),
        .address_width(32),
        .depth_words  (262144),
        .start_addr   (32'h8002_0000)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .address    (address),
        .data_in    (data_in),
        .access_size(access_size),
        .rw         (rw),
        .enable     (enable),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .range_err  (range_err)
    );

    typedef struct packed {
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] wdata [16];
    logic [31:0] last_out = '0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return ({32'b0, a} >= {32'b0, BASE}) && ({32'b0, a} < WIN_END);
    endfunction

    function automatic int blen(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (2 << s);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!in_win(a)) return 32'h0;
        if (model_mem.exists(a)) return model_mem[a];
        return 32'hDEAD_0000;
    endfunction

    // Monitor: pop one expectation per output beat; check hold otherwise.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            last_out = '0;
        end else if (data_valid || range_err) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: valid=%b err=%b with nothing expected", data_valid, range_err);
            end else begin
                e = expq.pop_front();
                check("data_valid", 32'(data_valid), 32'(e.rd));
                check("range_err", 32'(range_err), 32'(e.err));
                if (e.rd) begin
                    check("data_out", data_out, e.data);
                    last_out = e.data;
                end
            end
        end else begin
            check("hold", data_out, last_out);
        end
    end

    // Issue one request. stop_at >= 0 stops before that beat: by dropping
    // enable (abort) or, if stop_rst, by pulsing reset.
    task automatic do_req(input bit rd, input logic [1:0] sz, input logic [31:0] addr,
                          input int stop_at, input bit stop_rst);
        int          n;
        logic [31:0] base;
        logic [31:0] a;
        bit          inr;
        bit          stopped;
        n       = blen(sz);
        base    = addr & 32'hFFFF_FFFC;
        stopped = 1'b0;
        for (int k = 0; k < n && !stopped; k++) begin
            if (k == stop_at) begin
                stopped = 1'b1;
                enable  = 1'b0;
                if (stop_rst) begin
                    @(negedge clock);
                    #2 reset_n = 1'b0;
                    #1;
                    check("rst_busy", 32'(busy), 32'd0);
                    check("rst_valid", 32'(data_valid), 32'd0);
                    check("rst_dout", data_out, 32'd0);
                    @(negedge clock);
                    #2 reset_n = 1'b1;
                end else begin
                    address = $urandom;
                    data_in = $urandom;
                    @(posedge clock);
                    #1;
                    check("abort_busy", 32'(busy), 32'd0);
                end
            end else begin
                enable  = 1'b1;
                data_in = wdata[k];
                if (k == 0) begin
                    address     = addr;
                    rw          = rd;
                    access_size = sz;
                end else begin
                    address     = $urandom;
                    rw          = 1'($urandom);
                    access_size = 2'($urandom);
                end
                a   = base + 32'(4 * k);
                inr = in_win(a);
                if (!rd) begin
                    if (inr) model_mem[a] = wdata[k];
                    else expq.push_back('{rd: 1'b0, err: 1'b1, data: 32'h0});
                end else begin
                    expq.push_back('{rd: 1'b1, err: !inr, data: model_rd(a)});
                end
                @(posedge clock);
                #1;
                check("busy", 32'(busy), 32'(k < n - 1));
            end
        end
        enable = 1'b0;
    endtask

    task automatic single(input bit rd, input logic [31:0] addr, input logic [31:0] d);
        wdata[0] = d;
        do_req(rd, 2'b00, addr, -1, 1'b0);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 16; i++) wdata[i] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_err", 32'(range_err), 32'd0);
        check("reset_dout", data_out, 32'd0);
        #10 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Singles round-trip
        single(1'b0, BASE, 32'h27bd_fff8);
        single(1'b1, BASE, 32'h0);

        // 4-word write burst then single read-back
        wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
        wdata[2] = 32'h3333_3333; wdata[3] = 32'h4444_4444;
        do_req(1'b0, 2'b01, BASE + 32'h10, -1, 1'b0);
        for (int i = 0; i < 4; i++) single(1'b1, BASE + 32'h10 + 32'(4 * i), 32'h0);

        // Preload random-test regions
        for (int b = 0; b < 16; b++) begin
            rand_data();
            do_req(1'b0, 2'b11, BASE + 32'(64 * b), -1, 1'b0);
        end
        for (int b = 0; b < 4; b++) begin
            rand_data();
            do_req(1'b0, 2'b11, END_A - 32'd256 + 32'(64 * b), -1, 1'b0);
        end

        // 16-word read burst over index-valued words
        for (int i = 0; i < 16; i++) single(1'b0, BASE + 32'(4 * i), 32'(i));
        do_req(1'b1, 2'b11, BASE, -1, 1'b0);

        // Range errors at both window edges, with neighbour reads
        single(1'b0, BASE - 32'd4, 32'hBAD0_0001);
        single(1'b1, BASE - 32'd4, 32'h0);
        single(1'b0, END_A, 32'hBAD0_0002);
        single(1'b1, END_A, 32'h0);
        single(1'b1, BASE, 32'h0);
        single(1'b1, END_A - 32'd4, 32'h0);

        // Abort an 8-word write after 3 beats, then read the area back
        rand_data();
        do_req(1'b0, 2'b10, BASE + 32'h100, 3, 1'b0);
        do_req(1'b1, 2'b10, BASE + 32'h100, -1, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          r;
            int          stop;
            sz = 2'($urandom);
            r  = $urandom_range(0, 2);
            if (r == 0)      a = BASE + 32'(4 * $urandom_range(0, 240));
            else if (r == 1) a = BASE - 32'd64 + 32'(4 * $urandom_range(0, 15));
            else             a = END_A - 32'd256 + 32'(4 * $urandom_range(0, 63));
            a    = a | 32'($urandom_range(0, 3));
            stop = -1;
            if (blen(sz) > 1 && $urandom_range(0, 3) == 0) stop = $urandom_range(1, blen(sz) - 1);
            rand_data();
            do_req(1'($urandom), sz, a, stop, 1'b0);
        end

        // Reset in the middle of an 8-word read; RAM contents survive
        do_req(1'b1, 2'b10, BASE, 4, 1'b1);
        @(posedge clock);
        #1;
        single(1'b1, BASE + 32'h10, 32'h0);

        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Memory-side responder for the processor memory interface (clock, address, data_in, access_size, rw, enable, busy, data_out).
- Accepts single-word and burst read/write requests from an initiator (fetch/load-store unit, or a file-loading bench) and backs them with a word-organised RAM mapped at start_addr.
- Adds burst sequencing, a busy handshake, a read-data valid strobe and out-of-range detection.

Parameters:
- data_width, 32, word width in bits.
- address_width, 32, byte address width.
- depth_words, 262144, number of 32-bit words stored (1 MB).
- start_addr, 32'h80020000, byte address of word 0.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  address_width  byte address; sampled only when a request is accepted; bits [1:0] ignored.
- data_in  in  data_width  write data; sampled on every write beat edge.
- access_size  in  2  burst length: 00=1, 01=4, 10=8, 11=16 words.
- rw  in  1  0=write, 1=read.
- enable  in  1  request valid; must stay high for the whole burst.
- busy  out  1  high while a multi-beat burst has beats remaining after the current edge.
- data_out  out  data_width  registered read data.
- data_valid  out  1  one-cycle strobe per read beat; data_out is valid while it is high.
- range_err  out  1  one-cycle strobe for any beat whose address falls outside the mapped window.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, busy=0, data_out=0, data_valid=0, range_err=0, beat counter=0, address register=0. RAM contents are not cleared.
- States: IDLE, BURST_WR, BURST_RD.
- IDLE, enable=1 at edge E0:
  - Request is accepted.
  - base = {address[31:2],2'b00}.
  - beats_left = N-1, where N is from access_size.
  - Beat 0 executes at E0.
- Next state after E0:
  - N=1: stay IDLE, busy stays 0.
  - N>1: go to BURST_WR (rw=0) or BURST_RD (rw=1); busy=1 from E0.
- Beat k executes at edge Ek, on address base+4k. The address is incremented by 4 modulo 2^address_width and the initiator's address is ignored mid-burst.
- Write beat:
  - In range: RAM[(addr-start_addr)>>2] <= data_in.
  - Out of range: write dropped.
- Read beat:
  - data_out <= RAM word (0 if out of range); data_valid=1 for the cycle following Ek.
  - Read latency is 1 clock from the beat edge.
- In range means start_addr <= addr < start_addr + 4*depth_words, using an unsigned compare computed at full width plus 1 bit. Out-of-range beats pulse range_err.
- Last beat, edge E(N-1): busy <= 0, state <= IDLE. A new request may be accepted at the next edge, so there are no bubbles between back-to-back singles.
- enable=0 while in BURST_*: burst aborts at that edge. That beat is not executed, remaining beats are dropped, busy <= 0, state <= IDLE, and earlier writes persist.
- rw or access_size changes mid-burst are ignored; values latched at E0 govern.
- data_valid and range_err are 0 on every edge with no read beat or no error.
- data_out holds its last value when data_valid=0.
- Reset asserted mid-burst: immediate return to reset values; the partially completed burst is lost after its last executed beat.
- Simultaneous enable=1 and last beat: the new request is not accepted that edge. It is accepted on the following edge with busy=0.

Decomposition:
- Package mem_if_pkg:
  - access_size encodings SZ_1/SZ_4/SZ_8/SZ_16.
  - RW_WRITE=0 and RW_READ=1.
  - State enum.
  - burst_len(access_size) function returning 1/4/8/16.
  - Default START_ADDR.
- One sub-module, mem_word_ram: single-port synchronous word RAM, depth_words x data_width, with write enable and registered read.

Test Plan:
- Singles round-trip: write 32'h27bdfff8 to 80020000, then read 80020000. Expect data_valid high one cycle after the read edge, data_out=27bdfff8, busy never high.
- Write burst: 4-word write (access_size=01) at 80020010 with data 11111111, 22222222, 33333333, 44444444. Expect busy high for 3 cycles. Single reads of 80020010..8002001C return those values in order.
- Read burst: 16-word read at 80020000 after preloading 0..15 with their index. Expect 16 consecutive data_valid cycles carrying 0..15, and busy falling at the 16th beat edge.
- Range error: write/read at 8001FFFC and at start_addr+4*depth_words. Expect a range_err pulse each time, read data_out=0, and neighbouring in-range words unchanged.
- Abort: 8-word write at 80020100 with enable dropped after 3 beats. Expect only 80020100..80020108 written, 8002010C still at its old value, and busy=0 on the abort edge.
- Reset mid-burst: pull reset_n low asynchronously mid-way through an 8-word read. Expect busy, data_valid and data_out to be 0 immediately. A subsequent single read of previously written data returns the correct value.
